// File: rtl/router_pkg.sv
// router_pkg: shared router types, flit layout constants, XY routing and one-hot helpers
package router_pkg;
  localparam int FLIT_DATA_WIDTH = 32;
  localparam int NORTH = 0;
  localparam int SOUTH = 1;
  localparam int WEST  = 2;
  localparam int EAST  = 3;
  localparam int LOCAL = 4;
  typedef enum logic [1:0] {BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, HEAD_TAIL = 2'b11} flit_type_e;
  typedef enum logic [1:0] {IDLE, RC, VA, ACTIVE} vc_state_e;
  function automatic int route_compute(input int cur, input int dest, input int per_row);
    int cx = cur % per_row;
    int cy = cur / per_row;
    int dx = dest % per_row;
    int dy = dest / per_row;
    return dx > cx ? EAST : dx < cx ? WEST : dy > cy ? SOUTH : dy < cy ? NORTH : LOCAL;
  endfunction
  function automatic logic [31:0] index_2_one_hot(input int idx);
    return 32'd1 << idx;
  endfunction
  function automatic logic is_head(input logic [1:0] t);
    flit_type_e ft = flit_type_e'(t);
    return ft == HEAD || ft == HEAD_TAIL;
  endfunction
  function automatic logic is_tail(input logic [1:0] t);
    flit_type_e ft = flit_type_e'(t);
    return ft == TAIL || ft == HEAD_TAIL;
  endfunction
endpackage

// File: rtl/vc_fifo.sv
// vc_fifo: DEPTH-entry circular flit buffer; push/pop, empty and occupancy count, front flit on dout
//   clk, reset (async active-low), push, pop, din -> dout (front), empty, count
//   A push into a full buffer is accepted only when a pop happens in the same cycle.
module vc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic do_push, do_pop;
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (count != CW'(DEPTH) || do_pop);
  assign dout    = mem[rd];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (do_pop) rd <= (rd == PW'(DEPTH - 1)) ? '0 : rd + 1'b1;
      if (do_push) wr <= (wr == PW'(DEPTH - 1)) ? '0 : wr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
endmodule

// File: rtl/vc_input_port.sv
// vc_input_port: router input port with NUM_VC wormhole virtual channels (RC -> VA -> switch requests)
//   clk, reset (async active-low)
//   in_flit/in_valid/in_vc: upstream flits; route_req/va_req/sa_req: per-VC requests to allocators
//   va_grant/va_out_vc, sa_grant: allocator responses; out_*: registered dequeued flit
//   credit_valid/credit_vc: one credit per freed slot; proto_err: sticky protocol error
module vc_input_port
  import router_pkg::*;
#(
  parameter int NUM_PORTS      = 5,
  parameter int NUM_VC         = 4,
  parameter int BUF_DEPTH      = 4,
  parameter int NUM_ROUTERS    = 16,
  parameter int ROUTER_PER_ROW = 4,
  parameter int ROUTER_ID      = 0,
  parameter int VC_BITS        = $clog2(NUM_VC)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [FLIT_DATA_WIDTH-1:0]           in_flit,
  input  logic                                 in_valid,
  input  logic [VC_BITS-1:0]                   in_vc,
  output logic [NUM_VC-1:0][NUM_PORTS-1:0]     route_req,
  output logic [NUM_VC-1:0]                    va_req,
  input  logic [NUM_VC-1:0]                    va_grant,
  input  logic [NUM_VC-1:0][VC_BITS-1:0]       va_out_vc,
  output logic [NUM_VC-1:0]                    sa_req,
  input  logic [NUM_VC-1:0]                    sa_grant,
  output logic [FLIT_DATA_WIDTH-1:0]           out_flit,
  output logic                                 out_valid,
  output logic [VC_BITS-1:0]                   out_vc,
  output logic [NUM_PORTS-1:0]                 out_port,
  output logic                                 credit_valid,
  output logic [VC_BITS-1:0]                   credit_vc,
  output logic                                 proto_err
);
  localparam int RID_BITS = $clog2(NUM_ROUTERS);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  logic [NUM_VC-1:0][FLIT_DATA_WIDTH-1:0] front;
  logic [NUM_VC-1:0][CW-1:0] count;
  logic [NUM_VC-1:0] empty, push, pop, sa_pop, disc_ok, disc, drop;
  logic [NUM_VC-1:0][NUM_PORTS-1:0] route_port;
  logic [NUM_VC-1:0][VC_BITS-1:0] ovc;
  logic [VC_BITS-1:0] pop_idx;
  logic bad_grant;
  vc_state_e state [NUM_VC];
  vc_state_e nxt [NUM_VC];
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_fifo #(.WIDTH(FLIT_DATA_WIDTH), .DEPTH(BUF_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[v]),
      .pop   (pop[v]),
      .din   (in_flit),
      .dout  (front[v]),
      .empty (empty[v]),
      .count (count[v])
    );
  end
  // A stray non-head flit on an idle VC is discarded; only one discard per cycle and only
  // when no switch pop happens, so the single credit port can return its slot too.
  always_comb begin
    push    = '0;
    sa_pop  = '0;
    disc_ok = '0;
    drop    = '0;
    pop_idx = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      push[v]    = in_valid && in_vc == VC_BITS'(v);
      sa_pop[v]  = sa_grant[v] && $onehot(sa_grant) && state[v] == ACTIVE && !empty[v];
      disc_ok[v] = state[v] == IDLE && !empty[v] && !is_head(front[v][1:0]);
    end
    disc      = |sa_pop ? '0 : disc_ok & -disc_ok;
    pop       = sa_pop | disc;
    bad_grant = |(sa_grant & ~sa_pop);
    for (int v = 0; v < NUM_VC; v++) begin
      drop[v] = push[v] && count[v] == CW'(BUF_DEPTH) && !pop[v];
      if (pop[v]) pop_idx = VC_BITS'(v);
    end
  end
  always_comb begin
    nxt = state;
    for (int v = 0; v < NUM_VC; v++)
      case (state[v])
        IDLE:    if (!empty[v] && is_head(front[v][1:0])) nxt[v] = RC;
        RC:      nxt[v] = VA;
        VA:      if (va_grant[v]) nxt[v] = ACTIVE;
        ACTIVE:  if (sa_pop[v] && is_tail(front[v][1:0])) nxt[v] = IDLE;
        default: nxt[v] = IDLE;
      endcase
  end
  always_comb begin
    route_req = '0;
    va_req    = '0;
    sa_req    = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      route_req[v] = (state[v] == VA || state[v] == ACTIVE) ? route_port[v] : '0;
      va_req[v]    = state[v] == VA;
      sa_req[v]    = state[v] == ACTIVE && !empty[v];
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int v = 0; v < NUM_VC; v++) state[v] <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      route_port   <= '0;
      ovc          <= '0;
      out_flit     <= '0;
      out_valid    <= 1'b0;
      out_vc       <= '0;
      out_port     <= '0;
      credit_valid <= 1'b0;
      credit_vc    <= '0;
      proto_err    <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (state[v] == RC)
          route_port[v] <= NUM_PORTS'(index_2_one_hot(route_compute(ROUTER_ID,
                             int'(front[v][FLIT_DATA_WIDTH-1 -: RID_BITS]), ROUTER_PER_ROW)));
        if (state[v] == VA && va_grant[v]) ovc[v] <= va_out_vc[v];
      end
      out_valid <= |sa_pop;
      if (|sa_pop) begin
        out_flit <= front[pop_idx];
        out_vc   <= ovc[pop_idx];
        out_port <= route_port[pop_idx];
      end
      credit_valid <= |pop;
      if (|pop) credit_vc <= pop_idx;
      proto_err <= proto_err | bad_grant | (|disc) | (|drop);
    end
endmodule

// File: tb/tb_vc_input_port.sv
// tb_vc_input_port: directed scenario bench for vc_input_port with hand-computed expectations
module tb_vc_input_port;
  import router_pkg::*;
  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0;
  logic [31:0] in_flit = '0;
  logic [1:0] in_vc = '0;
  logic [3:0][4:0] route_req;
  logic [3:0] va_req, sa_req;
  logic [3:0] va_grant = '0, sa_grant = '0;
  logic [3:0][1:0] va_out_vc = '0;
  logic [31:0] out_flit;
  logic out_valid, credit_valid, proto_err;
  logic [1:0] out_vc, credit_vc;
  logic [4:0] out_port;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  vc_input_port dut (
    .clk(clk), .reset(reset), .in_flit(in_flit), .in_valid(in_valid), .in_vc(in_vc),
    .route_req(route_req), .va_req(va_req), .va_grant(va_grant), .va_out_vc(va_out_vc),
    .sa_req(sa_req), .sa_grant(sa_grant), .out_flit(out_flit), .out_valid(out_valid),
    .out_vc(out_vc), .out_port(out_port), .credit_valid(credit_valid), .credit_vc(credit_vc),
    .proto_err(proto_err)
  );
  function automatic logic [31:0] mk(input int dest, input int pl, input logic [1:0] t);
    return {4'(dest), 26'(pl), t};
  endfunction
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic push(input int vc, input logic [31:0] f);
    in_valid = 1'b1;
    in_vc = 2'(vc);
    in_flit = f;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic apply_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    va_grant = '0;
    sa_grant = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask
  task automatic test_reset();
    tick();
    checks++; if ({route_req, va_req, sa_req, out_valid, out_flit, out_vc, out_port, credit_valid, credit_vc, proto_err} !== '0) begin errors++; $display("FAIL reset_outputs: got nonzero outputs va=%b sa=%b ov=%b cv=%b pe=%b", va_req, sa_req, out_valid, credit_valid, proto_err); end
    reset = 1'b1;
    tick();
    checks++; if (va_req !== 4'b0000) begin errors++; $display("FAIL reset_idle_va: got %b expected 0000", va_req); end
  endtask
  task automatic test_head_tail();
    logic [31:0] f = mk(5, 'h2a, HEAD_TAIL);
    push(0, f);
    checks++; if (va_req !== 4'b0000) begin errors++; $display("FAIL t1_va_c0: got %b expected 0000", va_req); end
    tick();
    checks++; if (va_req !== 4'b0000) begin errors++; $display("FAIL t1_va_c1: got %b expected 0000", va_req); end
    tick();
    checks++; if (va_req !== 4'b0001) begin errors++; $display("FAIL t1_va_c2: got %b expected 0001", va_req); end
    checks++; if (route_req[0] !== 5'b01000) begin errors++; $display("FAIL t1_route: got %b expected 01000", route_req[0]); end
    va_grant = 4'b0001;
    va_out_vc[0] = 2'd2;
    tick();
    va_grant = '0;
    checks++; if (sa_req !== 4'b0001 || va_req !== 4'b0000) begin errors++; $display("FAIL t1_sa_req: got sa=%b va=%b expected 0001/0000", sa_req, va_req); end
    sa_grant = 4'b0001;
    tick();
    sa_grant = '0;
    checks++; if (out_valid !== 1'b1 || out_flit !== f) begin errors++; $display("FAIL t1_out: got v=%b %h expected 1 %h", out_valid, out_flit, f); end
    checks++; if (out_vc !== 2'd2 || out_port !== 5'b01000) begin errors++; $display("FAIL t1_out_vc_port: got %0d %b expected 2 01000", out_vc, out_port); end
    checks++; if (credit_valid !== 1'b1 || credit_vc !== 2'd0) begin errors++; $display("FAIL t1_credit: got %b vc=%0d expected 1 vc=0", credit_valid, credit_vc); end
    checks++; if (route_req[0] !== 5'b0 || sa_req !== 4'b0 || va_req !== 4'b0) begin errors++; $display("FAIL t1_idle: got route=%b sa=%b va=%b expected zeros", route_req[0], sa_req, va_req); end
    tick();
    checks++; if (out_valid !== 1'b0 || credit_valid !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL t1_quiet: got ov=%b cv=%b pe=%b expected 0 0 0", out_valid, credit_valid, proto_err); end
  endtask
  task automatic test_full_drop();
    logic [31:0] f [4];
    f[0] = mk(15, 'h11, HEAD);
    f[1] = mk(15, 'h12, BODY);
    f[2] = mk(15, 'h13, BODY);
    f[3] = mk(15, 'h14, TAIL);
    apply_reset();
    for (int i = 0; i < 4; i++) push(1, f[i]);
    checks++; if (proto_err !== 1'b0 || va_req !== 4'b0010) begin errors++; $display("FAIL t2_before_drop: got pe=%b va=%b expected 0 0010", proto_err, va_req); end
    push(1, mk(15, 'h99, BODY));
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL t2_drop_err: got %b expected 1", proto_err); end
    va_grant = 4'b0010;
    va_out_vc[1] = 2'd1;
    tick();
    va_grant = '0;
    for (int i = 0; i < 4; i++) begin
      sa_grant = 4'b0010;
      tick();
      checks++; if (out_valid !== 1'b1 || out_flit !== f[i] || out_vc !== 2'd1) begin errors++; $display("FAIL t2_order%0d: got v=%b %h vc=%0d expected 1 %h vc=1", i, out_valid, out_flit, out_vc, f[i]); end
      checks++; if (credit_valid !== 1'b1 || credit_vc !== 2'd1) begin errors++; $display("FAIL t2_credit%0d: got %b vc=%0d expected 1 vc=1", i, credit_valid, credit_vc); end
    end
    sa_grant = '0;
    checks++; if (sa_req !== 4'b0 || va_req !== 4'b0) begin errors++; $display("FAIL t2_idle: got sa=%b va=%b expected 0 0", sa_req, va_req); end
    tick();
    checks++; if (credit_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL t2_no_extra: got cv=%b ov=%b expected 0 0", credit_valid, out_valid); end
  endtask
  task automatic test_interleave();
    logic [31:0] h0 = mk(4, 'h40, HEAD), t0 = mk(4, 'h41, TAIL);
    logic [31:0] h3 = mk(1, 'h30, HEAD), t3 = mk(1, 'h31, TAIL);
    apply_reset();
    push(0, h0);
    push(3, h3);
    push(0, t0);
    push(3, t3);
    checks++; if (va_req !== 4'b1001) begin errors++; $display("FAIL t3_va: got %b expected 1001", va_req); end
    checks++; if (route_req[0] !== 5'b00010 || route_req[3] !== 5'b01000) begin errors++; $display("FAIL t3_route: got %b %b expected 00010 01000", route_req[0], route_req[3]); end
    va_grant = 4'b1001;
    va_out_vc = '0;
    va_out_vc[0] = 2'd3;
    tick();
    va_grant = '0;
    checks++; if (sa_req !== 4'b1001) begin errors++; $display("FAIL t3_sa: got %b expected 1001", sa_req); end
    sa_grant = 4'b0001;
    tick();
    checks++; if (out_flit !== h0 || out_vc !== 2'd3 || out_port !== 5'b00010 || credit_vc !== 2'd0) begin errors++; $display("FAIL t3_pop_h0: got %h vc=%0d port=%b cvc=%0d", out_flit, out_vc, out_port, credit_vc); end
    sa_grant = 4'b1000;
    tick();
    checks++; if (out_flit !== h3 || out_vc !== 2'd0 || out_port !== 5'b01000 || credit_vc !== 2'd3) begin errors++; $display("FAIL t3_pop_h3: got %h vc=%0d port=%b cvc=%0d", out_flit, out_vc, out_port, credit_vc); end
    sa_grant = 4'b0001;
    tick();
    checks++; if (out_flit !== t0 || credit_vc !== 2'd0 || sa_req !== 4'b1000 || route_req[0] !== 5'b0 || route_req[3] !== 5'b01000) begin errors++; $display("FAIL t3_tail0: got %h cvc=%0d sa=%b r0=%b r3=%b", out_flit, credit_vc, sa_req, route_req[0], route_req[3]); end
    sa_grant = 4'b1000;
    tick();
    sa_grant = '0;
    checks++; if (out_flit !== t3 || credit_vc !== 2'd3 || sa_req !== 4'b0 || route_req[3] !== 5'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL t3_tail3: got %h cvc=%0d sa=%b r3=%b pe=%b", out_flit, credit_vc, sa_req, route_req[3], proto_err); end
  endtask
  task automatic test_back_to_back();
    logic [31:0] f [5];
    f[0] = mk(2, 'h50, HEAD);
    f[1] = mk(2, 'h51, BODY);
    f[2] = mk(2, 'h52, BODY);
    f[3] = mk(2, 'h53, BODY);
    f[4] = mk(2, 'h54, TAIL);
    apply_reset();
    for (int i = 0; i < 4; i++) push(2, f[i]);
    va_grant = 4'b0100;
    va_out_vc[2] = 2'd1;
    tick();
    va_grant = '0;
    in_valid = 1'b1;
    in_vc = 2'd2;
    in_flit = f[4];
    sa_grant = 4'b0100;
    tick();
    in_valid = 1'b0;
    checks++; if (out_flit !== f[0] || credit_valid !== 1'b1 || credit_vc !== 2'd2 || proto_err !== 1'b0) begin errors++; $display("FAIL t4_pushpop: got %h cv=%b cvc=%0d pe=%b", out_flit, credit_valid, credit_vc, proto_err); end
    for (int i = 1; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_flit !== f[i] || out_port !== 5'b01000) begin errors++; $display("FAIL t4_drain%0d: got v=%b %h port=%b expected %h", i, out_valid, out_flit, out_port, f[i]); end
    end
    sa_grant = '0;
    checks++; if (sa_req !== 4'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL t4_end: got sa=%b pe=%b expected 0 0", sa_req, proto_err); end
  endtask
  task automatic test_body_first();
    apply_reset();
    push(2, mk(7, 'h60, BODY));
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL t5_pe_early: got %b expected 0", proto_err); end
    tick();
    checks++; if (proto_err !== 1'b1 || va_req !== 4'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL t5_discard: got pe=%b va=%b ov=%b expected 1 0 0", proto_err, va_req, out_valid); end
    checks++; if (credit_valid !== 1'b1 || credit_vc !== 2'd2) begin errors++; $display("FAIL t5_credit: got %b vc=%0d expected 1 vc=2", credit_valid, credit_vc); end
    push(2, mk(0, 'h61, HEAD_TAIL));
    tick();
    tick();
    checks++; if (va_req !== 4'b0100 || route_req[2] !== 5'b10000) begin errors++; $display("FAIL t5_next_head: got va=%b route=%b expected 0100 10000", va_req, route_req[2]); end
  endtask
  task automatic test_reset_mid_packet();
    apply_reset();
    push(1, mk(3, 'h70, HEAD));
    push(1, mk(3, 'h71, BODY));
    push(1, mk(3, 'h72, BODY));
    va_grant = 4'b0010;
    va_out_vc[1] = 2'd3;
    tick();
    va_grant = '0;
    sa_grant = 4'b0010;
    tick();
    sa_grant = '0;
    checks++; if (out_valid !== 1'b1 || sa_req !== 4'b0010) begin errors++; $display("FAIL t6_active: got ov=%b sa=%b expected 1 0010", out_valid, sa_req); end
    reset = 1'b0;
    #1;
    checks++; if ({route_req, va_req, sa_req, out_valid, out_flit, out_vc, out_port, credit_valid, credit_vc, proto_err} !== '0) begin errors++; $display("FAIL t6_async_clear: got ov=%b sa=%b cv=%b r1=%b", out_valid, sa_req, credit_valid, route_req[1]); end
    tick();
    reset = 1'b1;
    push(1, mk(5, 'h73, HEAD_TAIL));
    tick();
    tick();
    checks++; if (va_req !== 4'b0010 || route_req[1] !== 5'b01000 || proto_err !== 1'b0 || credit_valid !== 1'b0) begin errors++; $display("FAIL t6_after: got va=%b r1=%b pe=%b cv=%b expected 0010 01000 0 0", va_req, route_req[1], proto_err, credit_valid); end
  endtask
  initial begin
    test_reset();
    test_head_tail();
    test_full_drop();
    test_interleave();
    test_back_to_back();
    test_body_first();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
